// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver.
// Packed BCD digits are captured into a pending register on load and moved
// into the display shadow only at frame boundaries. This keeps every scanned
// frame consistent. Each digit slot opens with a dead-time window (all selects
// off) to suppress ghosting. Leading-zero blanking is optional.
module seg7_scan_driver #(
  parameter int unsigned DIGITS         = 2,
  parameter int unsigned SCAN_DIV       = 25000,
  parameter int unsigned BLANK_CYC      = 250,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic                  load,
  input  logic                  lz_en,
  output logic [6:0]            d,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_done
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PC_MAX  = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
  // Pin-level pattern for "all segments off".
  localparam logic [6:0] BLANK_PIN = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  // Segment patterns in g..a bit order. Non-BCD codes go dark rather than
  // showing a misleading shape.
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  logic [PW-1:0]       pc_q, pc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] pending_q, pending_d;
  logic                pend_vld_q, pend_vld_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                fdone_q, fdone_d;

  logic                pc_wrap;
  logic                frame_end;
  logic [31:0]         pc_ext;
  logic                in_dead;
  logic [3:0]          cur_dig;
  logic                cur_lz;
  logic [DIGITS-1:0]   sel_n;
  logic [DIGITS-1:0]   upper_zero;
  logic [6:0]          seg_raw;

  assign pc_wrap   = (pc_q == PC_MAX);
  assign frame_end = pc_wrap && (idx_q == IDX_MAX);
  assign pc_ext    = 32'(pc_q);
  assign in_dead   = (pc_ext < BLANK_CYC);

  // Prescaler and slot index: pc wraps every slot, idx advances on each wrap.
  always_comb begin
    pc_d  = pc_q + PW'(1);
    idx_d = idx_q;
    if (pc_wrap) begin
      pc_d  = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
  end

  // Pending capture and tear-free transfer to the shadow at frame boundaries.
  // A load on the boundary cycle bypasses the pending register, so the newest
  // value is the one displayed.
  always_comb begin
    pending_d  = pending_q;
    pend_vld_d = pend_vld_q;
    shadow_d   = shadow_q;
    if (load) begin
      pending_d  = digits_in;
      pend_vld_d = 1'b1;
    end
    if (frame_end && (load || pend_vld_q)) begin
      shadow_d   = load ? digits_in : pending_q;
      pend_vld_d = 1'b0;
    end
  end

  // upper_zero[k] is set when shadow digits k..DIGITS-1 are all zero.
  always_comb begin
    logic run;
    run        = 1'b1;
    upper_zero = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run           = run && (shadow_q[4*k +: 4] == 4'd0);
      upper_zero[k] = run;
    end
  end

  // Select the active digit and build its one-hot enable.
  always_comb begin
    cur_dig = 4'd0;
    cur_lz  = 1'b0;
    sel_n   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_dig  = shadow_q[4*k +: 4];
        cur_lz   = (k != 0) && upper_zero[k];
        sel_n[k] = 1'b1;
      end
    end
  end

  // Output stage: dead time first, then the decoded (possibly blanked) digit.
  always_comb begin
    seg_raw = (lz_en && cur_lz) ? 7'h00 : decode(cur_dig);
    sel_d   = '0;
    seg_d   = BLANK_PIN;
    fdone_d = frame_end;
    if (!in_dead) begin
      sel_d = sel_n;
      seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    end
  end

  // State and output registers. Reset blanks the display and drops any pending load.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      pending_q  <= '0;
      pend_vld_q <= 1'b0;
      seg_q      <= BLANK_PIN;
      sel_q      <= '0;
      fdone_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      pend_vld_q <= pend_vld_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
      fdone_q    <= fdone_d;
    end
  end

  assign d          = seg_q;
  assign sel        = sel_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (SCAN_DIV=8, BLANK_CYC=2, DIGITS=2).
// n counts rising edges since reset release; values are sampled 1 time unit
// after edge n. At that point the outputs reflect the state before edge n.
// Frames are 16 cycles long, so shadow updates happen at n = 16, 32, ...
module tb_seg7_scan_driver;

  logic       clk_in = 1'b0;
  logic       rst;
  logic [7:0] digits_in;
  logic       load;
  logic       lz_en;
  logic [6:0] d, d_al;
  logic [1:0] sel, sel_al;
  logic       frame_done, fd_al;

  int n      = 0;
  int tests  = 0;
  int failed = 0;

  seg7_scan_driver #(.DIGITS(2), .SCAN_DIV(8), .BLANK_CYC(2), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk_in(clk_in), .rst(rst), .digits_in(digits_in), .load(load), .lz_en(lz_en),
    .d(d), .sel(sel), .frame_done(frame_done)
  );

  seg7_scan_driver #(.DIGITS(2), .SCAN_DIV(8), .BLANK_CYC(2), .SEG_ACTIVE_LOW(1'b1)) dut_al (
    .clk_in(clk_in), .rst(rst), .digits_in(digits_in), .load(load), .lz_en(lz_en),
    .d(d_al), .sel(sel_al), .frame_done(fd_al)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp)
    else begin
      failed++;
      $error("FAIL %s at n=%0d observed=%h expected=%h", tag, n, got, exp);
    end
  endtask

  task automatic run_to(input int target);
    while (n < target) begin
      @(posedge clk_in);
      #1;
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; lz_en = 1'b0; digits_in = 8'h00;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_sel", {6'b0, sel}, 8'h00);
    chk("rst_d", {1'b0, d}, 8'h00);
    chk("rst_d_al", {1'b0, d_al}, 8'h7F);
    rst = 1'b0; n = 0;

    // First run: queue a pending load, then reset mid-scan.
    run_to(1); load = 1'b1; digits_in = 8'h77;
    run_to(2); load = 1'b0;
    run_to(3);
    chk("run1_sel", {6'b0, sel}, 8'h01);
    run_to(5);
    rst = 1'b1;
    #1;
    chk("async_sel", {6'b0, sel}, 8'h00);
    chk("async_d", {1'b0, d}, 8'h00);
    chk("async_d_al", {1'b0, d_al}, 8'h7F);
    chk("async_fd", {7'b0, frame_done}, 8'h00);
    @(posedge clk_in);
    #1;
    rst = 1'b0; n = 0;

    // Release latency: 2 dead cycles plus the output register.
    run_to(1); chk("rel1_sel", {6'b0, sel}, 8'h00);
    run_to(2); chk("rel2_sel", {6'b0, sel}, 8'h00);
    run_to(3); chk("rel3_sel", {6'b0, sel}, 8'h01);
    chk("rel3_d", {1'b0, d}, 8'h3F);
    run_to(15); chk("fd15", {7'b0, frame_done}, 8'h00);
    run_to(16); chk("fd16", {7'b0, frame_done}, 8'h01);
    run_to(17); chk("fd17", {7'b0, frame_done}, 8'h00);
    run_to(19); chk("discard_d", {1'b0, d}, 8'h3F);

    // Load 42 mid-frame; it must wait for the boundary. digits_in changes after the load.
    run_to(20); load = 1'b1; digits_in = 8'h42;
    run_to(21); load = 1'b0; digits_in = 8'h11;
    run_to(30); chk("hold_sel", {6'b0, sel}, 8'h02);
    chk("hold_d", {1'b0, d}, 8'h3F);
    run_to(32); chk("fd32", {7'b0, frame_done}, 8'h01);
    run_to(34); chk("dead0_sel", {6'b0, sel}, 8'h00);
    chk("dead0_d", {1'b0, d}, 8'h00);
    run_to(35); chk("f2_d0_sel", {6'b0, sel}, 8'h01);
    chk("f2_d0", {1'b0, d}, 8'h5B);
    run_to(42); chk("dead1_sel", {6'b0, sel}, 8'h00);
    run_to(43); chk("f2_d1_sel", {6'b0, sel}, 8'h02);
    chk("f2_d1", {1'b0, d}, 8'h66);
    run_to(48); chk("fd48", {7'b0, frame_done}, 8'h01);

    // Two loads in one frame: the later one is shown.
    run_to(49); load = 1'b1; digits_in = 8'h17;
    run_to(50); load = 1'b0;
    run_to(54); load = 1'b1; digits_in = 8'h35;
    run_to(55); load = 1'b0;
    run_to(67); chk("f4_d0", {1'b0, d}, 8'h6D);
    run_to(75); chk("f4_d1", {1'b0, d}, 8'h4F);

    // A load on the boundary cycle is captured directly.
    run_to(79); load = 1'b1; digits_in = 8'h99;
    run_to(80); load = 1'b0;
    chk("fd80", {7'b0, frame_done}, 8'h01);
    run_to(83); chk("f5_d0", {1'b0, d}, 8'h6F);
    chk("f5_d0_sel", {6'b0, sel}, 8'h01);
    // A pending value is overridden by a load on the boundary cycle.
    run_to(84); load = 1'b1; digits_in = 8'h12;
    run_to(85); load = 1'b0;
    run_to(91); chk("f5_d1", {1'b0, d}, 8'h6F);
    run_to(95); load = 1'b1; digits_in = 8'h34;
    run_to(96); load = 1'b0;
    run_to(99); chk("f6_d0", {1'b0, d}, 8'h66);

    // Leading-zero blanking.
    run_to(100); load = 1'b1; digits_in = 8'h05; lz_en = 1'b1;
    run_to(101); load = 1'b0;
    run_to(107); chk("f6_d1_lz", {1'b0, d}, 8'h4F);
    run_to(115); chk("lz05_d0", {1'b0, d}, 8'h6D);
    run_to(116); load = 1'b1; digits_in = 8'h00;
    run_to(117); load = 1'b0;
    run_to(123); chk("lz05_d1", {1'b0, d}, 8'h00);
    chk("lz05_d1_sel", {6'b0, sel}, 8'h02);
    run_to(131); chk("lz00_d0", {1'b0, d}, 8'h3F);
    run_to(132); load = 1'b1; digits_in = 8'h50;
    run_to(133); load = 1'b0;
    run_to(139); chk("lz00_d1", {1'b0, d}, 8'h00);
    run_to(147); chk("lz50_d0", {1'b0, d}, 8'h3F);
    run_to(148); load = 1'b1; digits_in = 8'hAF; lz_en = 1'b0;
    run_to(149); load = 1'b0;
    run_to(155); chk("lz50_d1", {1'b0, d}, 8'h6D);

    // Non-BCD codes are blank. Also checks the active-low instance.
    run_to(163); chk("af_d0", {1'b0, d}, 8'h00);
    chk("af_d0_sel", {6'b0, sel}, 8'h01);
    run_to(164); load = 1'b1; digits_in = 8'h08;
    run_to(165); load = 1'b0;
    run_to(171); chk("af_d1", {1'b0, d}, 8'h00);
    run_to(178); chk("al_dead_d", {1'b0, d_al}, 8'h7F);
    chk("al_dead_sel", {6'b0, sel_al}, 8'h00);
    run_to(179); chk("hi_08_d0", {1'b0, d}, 8'h7F);
    chk("al_08_d0", {1'b0, d_al}, 8'h00);
    chk("al_08_sel", {6'b0, sel_al}, 8'h01);
    run_to(187); chk("hi_08_d1", {1'b0, d}, 8'h3F);
    chk("al_08_d1", {1'b0, d_al}, 8'h40);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
